// File: rtl/test_fifo_if.sv
// rtl/test_fifo_if.sv - write/read handshake and status bundle for test_fifo.
// rd_data_count exists only when TEST_FIFO_DATA_COUNT_EN is defined.
interface test_fifo_if #(
  parameter int DEPTH = 256
);
  logic [15:0]  din;
  logic         wr_en;
  logic         rd_en;
  logic [127:0] dout;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;
`ifdef TEST_FIFO_DATA_COUNT_EN
  logic [$clog2(DEPTH):0] rd_data_count;
`endif

  modport master (
    output din, wr_en, rd_en,
    input  dout, empty, full, overflow, underflow
`ifdef TEST_FIFO_DATA_COUNT_EN
    , input rd_data_count
`endif
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, empty, full, overflow, underflow
`ifdef TEST_FIFO_DATA_COUNT_EN
    , output rd_data_count
`endif
  );
endinterface

// File: rtl/test_fifo.sv
// rtl/test_fifo.sv - 16-bit in, 128-bit out width-converting FIFO, first write in the MSBs.
// Optional TEST_FIFO_DATA_COUNT_EN adds rd_data_count (complete words stored).
module test_fifo #(
  parameter int DEPTH = 256
) (
  input logic       clk,
  input logic       rst,
  test_fifo_if.slave bus
);
  localparam int ENTRIES = DEPTH * 8;
  localparam int AW      = $clog2(ENTRIES);
  localparam int WW      = $clog2(DEPTH);

  typedef logic [AW:0] count_t;

  // Storage is word-organised; each 16-bit write lands directly in its lane.
  logic [7:0][15:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [WW-1:0] r_rd_ptr;
  count_t        r_hw_count;
  logic [127:0]  r_dout;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_wr_acc;
  logic          w_rd_acc;
  count_t        w_count_next;
  logic [WW-1:0] w_wr_word;
  logic [2:0]    w_wr_lane;

  assign w_wr_word = r_wr_ptr[AW-1:3];
  assign w_wr_lane = r_wr_ptr[2:0];

  // Both strobes are judged against the flags registered at the start of the cycle.
  always_comb begin
    w_wr_acc     = bus.wr_en & ~r_full;
    w_rd_acc     = bus.rd_en & ~r_empty;
    w_count_next = r_hw_count + count_t'(w_wr_acc) - (w_rd_acc ? count_t'(8) : count_t'(0));
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[w_wr_word][3'd7 - w_wr_lane] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_hw_count  <= '0;
      r_dout      <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + WW'(1);
      end
      r_hw_count  <= w_count_next;
      r_empty     <= (w_count_next < count_t'(8));
      r_full      <= (w_count_next == count_t'(ENTRIES));
      r_overflow  <= bus.wr_en & r_full;
      r_underflow <= bus.rd_en & r_empty;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.empty     = r_empty;
  assign bus.full      = r_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

`ifdef TEST_FIFO_DATA_COUNT_EN
  logic [WW:0] r_rd_data_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data_count <= '0;
    end else begin
      r_rd_data_count <= w_count_next[AW:3];
    end
  end

  assign bus.rd_data_count = r_rd_data_count;
`endif
endmodule

// File: tb/tb_test_fifo.sv
// tb/tb_test_fifo.sv - randomized self-checking bench for test_fifo against a queue model.
module tb_test_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst2;

  test_fifo_if #(.DEPTH(4)) if4 ();
  test_fifo_if #(.DEPTH(2)) if2 ();

  test_fifo #(.DEPTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));
  test_fifo #(.DEPTH(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(if2));

  int checks = 0;
  int errors = 0;

  logic [15:0]  q4[$];
  logic [15:0]  q2[$];
  logic [127:0] m_dout4;
  logic [127:0] m_dout2;
  logic         m_ovf4;
  logic         m_unf4;

  function automatic logic [127:0] pop_word4();
    logic [127:0] w = '0;
    for (int k = 0; k < 8; k++) w = {w[111:0], q4.pop_front()};
    return w;
  endfunction

  function automatic logic [127:0] pop_word2();
    logic [127:0] w = '0;
    for (int k = 0; k < 8; k++) w = {w[111:0], q2.pop_front()};
    return w;
  endfunction

  task automatic reset4();
    rst4 = 1'b1;
    if4.wr_en = 1'b0; if4.rd_en = 1'b0; if4.din = '0;
    @(posedge clk);
    q4.delete(); m_dout4 = '0; m_ovf4 = 1'b0; m_unf4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
  endtask

  task automatic reset2();
    rst2 = 1'b1;
    if2.wr_en = 1'b0; if2.rd_en = 1'b0; if2.din = '0;
    @(posedge clk);
    q2.delete(); m_dout2 = '0;
    @(negedge clk);
    rst2 = 1'b0;
  endtask

  task automatic cycle4(input logic wr, input logic [15:0] d, input logic rd);
    bit pre_full, pre_empty;
    if4.wr_en = wr; if4.din = d; if4.rd_en = rd;
    pre_full  = (q4.size() == 32);
    pre_empty = (q4.size() < 8);
    @(posedge clk);
    m_ovf4 = wr && pre_full;
    m_unf4 = rd && pre_empty;
    if (rd && !pre_empty) m_dout4 = pop_word4();
    if (wr && !pre_full) q4.push_back(d);
    @(negedge clk);
    if4.wr_en = 1'b0; if4.rd_en = 1'b0;
  endtask

  task automatic cycle2(input logic wr, input logic [15:0] d, input logic rd);
    bit pre_full, pre_empty;
    if2.wr_en = wr; if2.din = d; if2.rd_en = rd;
    pre_full  = (q2.size() == 16);
    pre_empty = (q2.size() < 8);
    @(posedge clk);
    if (rd && !pre_empty) m_dout2 = pop_word2();
    if (wr && !pre_full) q2.push_back(d);
    @(negedge clk);
    if2.wr_en = 1'b0; if2.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset4();
    checks += 5;
    if (if4.dout !== 128'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", if4.dout); end
    if (if4.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", if4.empty); end
    if (if4.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", if4.full); end
    if (if4.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", if4.overflow); end
    if (if4.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", if4.underflow); end
  endtask

  task automatic test_basic();
    logic [127:0] exp_w;
    exp_w = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    for (int i = 1; i <= 8; i++) begin
      cycle4(1'b1, 16'(i), 1'b0);
      checks++;
      if (if4.empty !== (i < 8)) begin
        errors++; $display("FAIL basic_empty write %0d got %b exp %b", i, if4.empty, (i < 8));
      end
    end
    cycle4(1'b0, '0, 1'b1);
    checks += 3;
    if (if4.dout !== exp_w) begin errors++; $display("FAIL basic_dout got %h exp %h", if4.dout, exp_w); end
    if (m_dout4 !== exp_w) begin errors++; $display("FAIL basic_model got %h exp %h", m_dout4, exp_w); end
    if (if4.empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after_read got %b exp 1", if4.empty); end
  endtask

  task automatic test_underflow();
    logic [127:0] prev;
    prev = m_dout4;
    cycle4(1'b0, '0, 1'b1);
    checks += 3;
    if (if4.underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse got %b exp 1", if4.underflow); end
    if (if4.dout !== prev) begin errors++; $display("FAIL underflow_dout got %h exp %h", if4.dout, prev); end
    if (if4.empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got %b exp 1", if4.empty); end
    cycle4(1'b0, '0, 1'b0);
    checks++;
    if (if4.underflow !== 1'b0) begin errors++; $display("FAIL underflow_width got %b exp 0", if4.underflow); end
  endtask

  task automatic test_overflow();
    logic [15:0]  data [16];
    logic [127:0] exp_w;
    reset2();
    for (int i = 0; i < 16; i++) begin
      data[i] = 16'($urandom);
      if (data[i] == 16'hFFFF) data[i] = 16'h1234;
      cycle2(1'b1, data[i], 1'b0);
      checks++;
      if (if2.full !== (i == 15)) begin
        errors++; $display("FAIL ovf_full write %0d got %b exp %b", i, if2.full, (i == 15));
      end
    end
    cycle2(1'b1, 16'hFFFF, 1'b0);
    checks += 2;
    if (if2.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", if2.overflow); end
    if (if2.full !== 1'b1) begin errors++; $display("FAIL ovf_full_hold got %b exp 1", if2.full); end
    cycle2(1'b0, '0, 1'b0);
    checks++;
    if (if2.overflow !== 1'b0) begin errors++; $display("FAIL ovf_width got %b exp 0", if2.overflow); end
    for (int w = 0; w < 2; w++) begin
      exp_w = {data[8*w], data[8*w+1], data[8*w+2], data[8*w+3],
               data[8*w+4], data[8*w+5], data[8*w+6], data[8*w+7]};
      cycle2(1'b0, '0, 1'b1);
      checks++;
      if (if2.dout !== exp_w) begin
        errors++; $display("FAIL ovf_read%0d got %h exp %h", w, if2.dout, exp_w);
      end
    end
    checks++;
    if (if2.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_end got %b exp 1", if2.empty); end
  endtask

  task automatic test_streaming();
    int written = 0;
    int reads = 0;
    int cyc = 0;
    logic wr, rd;
    reset4();
    while (reads < 100 && cyc < 8000) begin
      wr = (written < 800) && (q4.size() < 32) && ($urandom_range(0, 3) != 0);
      if (((cyc / 150) % 2) == 0) rd = (q4.size() >= 8) && ($urandom_range(0, 9) == 0);
      else                        rd = (q4.size() >= 8) && ($urandom_range(0, 1) == 0);
      if (rd) reads++;
      if (wr) written++;
      cycle4(wr, 16'($urandom), rd);
      cyc++;
      checks += 5;
      if (if4.dout !== m_dout4) begin errors++; $display("FAIL stream_dout cyc %0d got %h exp %h", cyc, if4.dout, m_dout4); end
      if (if4.empty !== (q4.size() < 8)) begin errors++; $display("FAIL stream_empty cyc %0d got %b exp %b", cyc, if4.empty, (q4.size() < 8)); end
      if (if4.full !== (q4.size() == 32)) begin errors++; $display("FAIL stream_full cyc %0d got %b exp %b", cyc, if4.full, (q4.size() == 32)); end
      if (if4.overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow cyc %0d got %b exp 0", cyc, if4.overflow); end
      if (if4.underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow cyc %0d got %b exp 0", cyc, if4.underflow); end
    end
    checks++;
    if (reads != 100) begin errors++; $display("FAIL stream_reads got %0d exp 100", reads); end
  endtask

  task automatic test_reset_mid();
    logic [15:0]  nd [8];
    logic [127:0] exp_w;
    for (int i = 0; i < 5; i++) cycle4(1'b1, 16'hA000 + 16'(i), 1'b0);
    reset4();
    checks += 2;
    if (if4.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", if4.empty); end
    if (if4.full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b exp 0", if4.full); end
    exp_w = '0;
    for (int i = 0; i < 8; i++) begin
      nd[i] = 16'($urandom);
      exp_w = {exp_w[111:0], nd[i]};
      cycle4(1'b1, nd[i], 1'b0);
    end
    cycle4(1'b0, '0, 1'b1);
    checks++;
    if (if4.dout !== exp_w) begin errors++; $display("FAIL rstmid_dout got %h exp %h", if4.dout, exp_w); end
  endtask

`ifdef TEST_FIFO_DATA_COUNT_EN
  task automatic test_data_count();
    reset4();
    for (int i = 0; i < 24; i++) cycle4(1'b1, 16'($urandom), 1'b0);
    checks++;
    if (if4.rd_data_count !== 3'd3) begin errors++; $display("FAIL count_after_writes got %0d exp 3", if4.rd_data_count); end
    cycle4(1'b0, '0, 1'b1);
    checks++;
    if (if4.rd_data_count !== 3'd2) begin errors++; $display("FAIL count_after_read got %0d exp 2", if4.rd_data_count); end
  endtask
`endif

  initial begin
    rst4 = 1'b1; rst2 = 1'b1;
    if4.din = '0; if4.wr_en = 1'b0; if4.rd_en = 1'b0;
    if2.din = '0; if2.wr_en = 1'b0; if2.rd_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_streaming();
    test_reset_mid();
`ifdef TEST_FIFO_DATA_COUNT_EN
    test_data_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/test_fifo.md
Name: test_fifo

Overview:
- Single-clock, width-converting FIFO.
- Accepts 16-bit words from the host pipe-in endpoint and delivers 128-bit frames to the clock-segment sequencer.
- Eight consecutive 16-bit writes form one 128-bit read word; the first write lands in the most significant bits.
- Provides empty/full status and one-cycle overflow/underflow error pulses.

Parameters:
- DEPTH, 256, capacity in 128-bit read words; power of two, minimum 2. Write capacity is DEPTH*8 16-bit entries.

Ports:
- clk  input  1  single clock for both write and read sides
- rst  input  1  synchronous active-high reset
- din  input  16  write data
- wr_en  input  1  write strobe; one 16-bit entry per asserted cycle
- rd_en  input  1  read strobe; one 128-bit word per asserted cycle
- dout  output  128  read data, registered
- empty  output  1  no complete 128-bit word available
- full  output  1  no room for another 16-bit write
- overflow  output  1  one-cycle pulse: a write was rejected
- underflow  output  1  one-cycle pulse: a read was rejected

Behaviour:
- Reset (rst=1 at a clk edge) clears all pointers and counts. Partially assembled words are discarded.
- Values after reset: dout=0, empty=1, full=0, overflow=0, underflow=0.
- rst has priority over wr_en and rd_en in the same cycle.
- Internal occupancy is tracked in 16-bit entries, hw_count, range 0..DEPTH*8.
- empty = (hw_count < 8). full = (hw_count == DEPTH*8). Both are registered and reflect the state after the previous edge.
- Write: if wr_en and !full, din is stored at the write pointer and hw_count is incremented.
- Packing order: entry k (k=0..7) of a word maps to dout[127-16k -: 16]. The first write goes to dout[127:112]; the eighth goes to dout[15:0].
- Read: if rd_en and !empty, the next complete word is loaded into dout on that edge and hw_count decreases by 8. dout is therefore valid from the cycle after rd_en is sampled. Latency is 1 clock.
- dout holds its value until the next accepted read.
- Write rejected (wr_en and full): data is dropped, overflow=1 for exactly the next cycle, and state is unchanged.
- Read rejected (rd_en and empty): dout is unchanged, underflow=1 for exactly the next cycle.
- Simultaneous wr_en and rd_en are legal. Each is judged against the empty/full flags at the start of the cycle.
  - A write that completes the 8th entry does not make a same-cycle read valid; that read underflows.
  - A read from a full FIFO does not admit a same-cycle write; that write overflows.
  - When both are accepted, the net hw_count change is +1-8.
- Pointers wrap modulo DEPTH*8 entries. After wrap-around, data order is preserved with no loss.
- Flag updates after an accepted operation:
  - empty deasserts on the edge that stores the 8th entry of a word.
  - full asserts on the edge that stores the final free entry.
  - full deasserts on the edge of an accepted read.
- No first-word-fall-through; dout is only updated by an accepted read.

Optional Feature:
- Macro TEST_FIFO_DATA_COUNT_EN.
- When defined: adds output rd_data_count of width $clog2(DEPTH)+1, equal to the number of complete 128-bit words stored (hw_count/8). It is registered, updates on the same edge as empty/full, and resets to 0.
- When not defined: the port does not exist and there is no counting logic beyond what the flags need.

Test Plan:
- Reset, then write 16'h0001..16'h0008 on consecutive cycles, then pulse rd_en.
  - empty stays 1 through the 7th write and is 0 after the 8th.
  - One cycle after rd_en, dout=128'h0001_0002_0003_0004_0005_0006_0007_0008 and empty=1.
- Pulse rd_en while empty.
  - underflow=1 for exactly one cycle; dout keeps its previous value; empty stays 1.
- With DEPTH=2, write 16 entries, then write 16'hFFFF.
  - full=1 after the 16th write.
  - overflow pulses for one cycle and the extra word is absent from both subsequent reads.
- Continuous streaming: with DEPTH=4, 100 words are written and read interleaved across several pointer wraps, including cycles with wr_en and rd_en both asserted.
  - All 100 128-bit words are read back in order.
  - No overflow or underflow occurs.
- Write 5 entries, assert rst for one cycle, then write 8 new entries and read.
  - dout contains only the 8 new entries; empty=1 and full=0 immediately after reset.
- With TEST_FIFO_DATA_COUNT_EN defined, write 24 entries and read once.
  - rd_data_count is 3 after the writes and 2 one cycle after the read.
